// File: rtl/ram_stream_reader.sv
// Streams LENGTH consecutive words from a dual_port_ram read port as a valid/ready stream with a 2-entry skid buffer.
// Define RAM_STREAM_READER_CHECKSUM_EN to add an XOR checksum of the transferred beats.
module ram_stream_reader #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   length,
   output logic [ADDR_W-1:0] read_addr,
   input  logic [DATA_W-1:0] ram_dout,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              m_last,
   output logic              busy,
`ifdef RAM_STREAM_READER_CHECKSUM_EN
   output logic [DATA_W-1:0] checksum,
`endif
   output logic              done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      ZERO  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   state_t            state_r;
   state_t            state_n_s;
   logic [ADDR_W-1:0] cur_addr_r;
   logic [ADDR_W-1:0] read_addr_r;
   logic [ADDR_W:0]   length_r;
   logic [ADDR_W:0]   issued_r;
   logic [ADDR_W:0]   beat_cnt_r;
   logic              in_flight_r;
   logic [DATA_W-1:0] buf_r [2];
   logic              head_r;
   logic [1:0]        count_r;
   logic              busy_r;
   logic              done_r;
   logic              accept_s;
   logic              issue_s;
   logic              pop_s;
   logic              last_beat_s;
   logic              done_set_s;
   logic [2:0]        occ_s;

   assign accept_s    = (state_r == IDLE) && start;
   assign m_valid     = (count_r != 2'd0);
   assign pop_s       = m_valid && m_ready;
   assign last_beat_s = m_valid && (beat_cnt_r == (length_r - {{ADDR_W{1'b0}}, 1'b1}));
   // Occupancy after this cycle's pop, so a full pipeline can still issue while draining at 1 beat/cycle.
   assign occ_s       = {2'b00, in_flight_r} + {1'b0, count_r} - {2'b00, pop_s};

   assign read_addr = issue_s ? cur_addr_r : read_addr_r;
   assign m_data    = buf_r[head_r];
   assign m_last    = last_beat_s;
   assign busy      = busy_r;
   assign done      = done_r;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_n_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_n_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               state_n_s = (length == {(ADDR_W+1){1'b0}}) ? ZERO : READ;
            end else begin
               state_n_s = IDLE;
            end
         end
         READ: begin
            if (issued_r == length_r) begin
               state_n_s = DRAIN;
            end else begin
               state_n_s = READ;
            end
         end
         ZERO:  state_n_s = IDLE;
         DRAIN: begin
            if (pop_s && last_beat_s) begin
               state_n_s = IDLE;
            end else begin
               state_n_s = DRAIN;
            end
         end
         default: state_n_s = IDLE;
      endcase
   end

   // FSM outputs: read issue and done request
   always_comb begin
      issue_s    = 1'b0;
      done_set_s = 1'b0;
      case (state_r)
         READ: begin
            if ((issued_r != length_r) && (occ_s < 3'd2)) begin
               issue_s = 1'b1;
            end else begin
               issue_s = 1'b0;
            end
         end
         ZERO:    done_set_s = 1'b1;
         DRAIN:   done_set_s = pop_s && last_beat_s;
         default: begin
            issue_s    = 1'b0;
            done_set_s = 1'b0;
         end
      endcase
   end

   // Request bookkeeping, skid buffer and status registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cur_addr_r  <= {ADDR_W{1'b0}};
         read_addr_r <= {ADDR_W{1'b0}};
         length_r    <= {(ADDR_W+1){1'b0}};
         issued_r    <= {(ADDR_W+1){1'b0}};
         beat_cnt_r  <= {(ADDR_W+1){1'b0}};
         in_flight_r <= 1'b0;
         buf_r[0]    <= {DATA_W{1'b0}};
         buf_r[1]    <= {DATA_W{1'b0}};
         head_r      <= 1'b0;
         count_r     <= 2'd0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         if (accept_s) begin
            cur_addr_r <= base_addr;
            length_r   <= length;
            issued_r   <= {(ADDR_W+1){1'b0}};
            beat_cnt_r <= {(ADDR_W+1){1'b0}};
         end else begin
            if (issue_s) begin
               cur_addr_r <= cur_addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
               issued_r   <= issued_r + {{ADDR_W{1'b0}}, 1'b1};
            end
            if (pop_s) begin
               beat_cnt_r <= beat_cnt_r + {{ADDR_W{1'b0}}, 1'b1};
            end
         end
         if (issue_s) begin
            read_addr_r <= cur_addr_r;
         end
         in_flight_r <= issue_s;
         // Tail slot is head+count; with count==2 a push only happens alongside a pop of that slot.
         if (in_flight_r) begin
            buf_r[head_r ^ count_r[0]] <= ram_dout;
         end
         head_r  <= head_r ^ pop_s;
         count_r <= count_r + {1'b0, in_flight_r} - {1'b0, pop_s};
         busy_r  <= (state_n_s != IDLE);
         done_r  <= done_set_s;
      end
   end

`ifdef RAM_STREAM_READER_CHECKSUM_EN
   logic [DATA_W-1:0] checksum_r;

   assign checksum = checksum_r;

   // XOR of every transferred beat, cleared on each accepted start
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         checksum_r <= {DATA_W{1'b0}};
      end else if (accept_s) begin
         checksum_r <= {DATA_W{1'b0}};
      end else if (pop_s) begin
         checksum_r <= checksum_r ^ m_data;
      end else begin
         checksum_r <= checksum_r;
      end
   end
`endif

endmodule
